// File: rtl/inv_cipher_core.sv
// inv_cipher_core: block-serial AES-128 decryption, one round per clock, inverse S-box built on chip.
// Optional build macro ROUND_KEY_CACHE_EN keeps rk0..rk10 in registers instead of deriving keys backwards.
module inv_cipher_core #(
   parameter int NUM_ROUNDS = 10,
   parameter int DATA_W     = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2047:0]     sbox_in,
   input  logic              sbox_in_vld,
   input  logic [DATA_W-1:0] key_in,
   input  logic              key_in_vld,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_vld,
   output logic              data_accept,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_vld,
   output logic              sbox_available,
   output logic              key_available
);

   typedef enum logic [1:0] {IDLE, INV_BUILD, KEY_EXP, DEC} state_t;

   localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS - 1);
   localparam logic [3:0] KEY_STEPS = 4'(NUM_ROUNDS);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] k);
      case (k)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t       r_state;
   logic [7:0]   r_cnt;
   logic [3:0]   r_rnd;
   logic         r_last;
   logic         r_sbox_ok;
   logic         r_key_ok;
   logic [127:0] r_blk;
   logic [127:0] r_wkey;
   logic [127:0] r_rk10;
   logic [127:0] r_dout;
   logic         r_dout_vld;
   logic [7:0]   r_fwd [256];
   logic [7:0]   r_inv [256];
`ifdef ROUND_KEY_CACHE_EN
   logic [127:0] r_rk [11];
`endif

   logic         w_idle;
   logic         w_hs;
   logic [31:0]  w_sw_in;
   logic [31:0]  w_sub_word;
   logic [7:0]   w_rcon;
   logic [127:0] w_key_next;
   logic [127:0] w_rk;
   logic [127:0] w_shift;
   logic [127:0] w_sub;
   logic [127:0] w_ark;
   logic [127:0] w_mix;
   logic [127:0] w_round;
`ifndef ROUND_KEY_CACHE_EN
   logic [127:0] w_key_prev;
`endif

   assign w_idle         = (r_state == IDLE);
   assign data_accept    = w_idle & r_sbox_ok & r_key_ok & ~key_in_vld & ~sbox_in_vld;
   assign w_hs           = data_in_vld & data_accept;
   assign data_out       = r_dout;
   assign data_out_vld   = r_dout_vld;
   assign sbox_available = r_sbox_ok;
   assign key_available  = r_key_ok;

   // One SubWord lookup serves forward expansion (KEY_EXP) and backward derivation (DEC).
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_sub_word = '0;
      w_key_next = '0;
`ifdef ROUND_KEY_CACHE_EN
      w_rcon  = rcon(r_rnd);
      w_sw_in = {r_wkey[23:0], r_wkey[31:24]};
      w_rk    = r_rk[r_rnd];
`else
      w_key_prev         = '0;
      w_key_prev[31:0]   = r_wkey[31:0]  ^ r_wkey[63:32];
      w_key_prev[63:32]  = r_wkey[63:32] ^ r_wkey[95:64];
      w_key_prev[95:64]  = r_wkey[95:64] ^ r_wkey[127:96];
      if (r_state == DEC) begin
         w_rcon  = rcon(r_rnd + 4'd1);
         w_sw_in = {w_key_prev[23:0], w_key_prev[31:24]};
      end else begin
         w_rcon  = rcon(r_rnd);
         w_sw_in = {r_wkey[23:0], r_wkey[31:24]};
      end
`endif
      for (int i = 0; i < 4; i++) begin
         w_sub_word[31-8*i -: 8] = r_fwd[w_sw_in[31-8*i -: 8]];
      end
      w_key_next[127:96] = r_wkey[127:96] ^ w_sub_word ^ {w_rcon, 24'h0};
      w_key_next[95:64]  = r_wkey[95:64]  ^ w_key_next[127:96];
      w_key_next[63:32]  = r_wkey[63:32]  ^ w_key_next[95:64];
      w_key_next[31:0]   = r_wkey[31:0]   ^ w_key_next[63:32];
`ifndef ROUND_KEY_CACHE_EN
      w_key_prev[127:96] = r_wkey[127:96] ^ w_sub_word ^ {w_rcon, 24'h0};
      w_rk               = w_key_prev;
`endif
   end

   // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns except on the last round.
   always_comb begin
      w_shift = '0;
      w_sub   = '0;
      w_mix   = '0;
      for (int b = 0; b < 16; b++) begin
         w_shift[127-8*b -: 8] = r_blk[127-8*(4*(((b/4) - (b%4)) & 3) + (b%4)) -: 8];
      end
      for (int b = 0; b < 16; b++) begin
         w_sub[127-8*b -: 8] = r_inv[w_shift[127-8*b -: 8]];
      end
      w_ark = w_sub ^ w_rk;
      for (int c = 0; c < 4; c++) begin
         w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
      end
      w_round = (r_rnd == 4'd0) ? w_ark : w_mix;
   end

   // NOTE: sequential state is written only with non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rnd      <= '0;
         r_last     <= 1'b0;
         r_sbox_ok  <= 1'b0;
         r_key_ok   <= 1'b0;
         r_blk      <= '0;
         r_wkey     <= '0;
         r_rk10     <= '0;
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         r_dout_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (sbox_in_vld) begin
                  r_state   <= INV_BUILD;
                  r_cnt     <= 8'd0;
                  r_sbox_ok <= 1'b0;
                  r_key_ok  <= 1'b0;
               end else if (key_in_vld && r_sbox_ok) begin
                  r_state  <= KEY_EXP;
                  r_wkey   <= key_in;
                  r_rnd    <= 4'd1;
                  r_key_ok <= 1'b0;
               end else if (w_hs) begin
                  r_state <= DEC;
                  r_blk   <= data_in ^ r_rk10;
                  r_wkey  <= r_rk10;
                  r_rnd   <= LAST_RND;
                  r_last  <= 1'b0;
               end
            end
            INV_BUILD: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'hff) begin
                  r_sbox_ok <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            KEY_EXP: begin
               r_wkey <= w_key_next;
               r_rnd  <= r_rnd + 4'd1;
               if (r_rnd == KEY_STEPS) begin
                  r_rk10   <= w_key_next;
                  r_key_ok <= 1'b1;
                  r_state  <= IDLE;
               end
            end
            DEC: begin
               // One drain cycle after the result keeps the block period at 12 cycles.
               if (r_last) begin
                  r_last  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_blk <= w_round;
`ifndef ROUND_KEY_CACHE_EN
                  r_wkey <= w_key_prev;
`endif
                  r_rnd <= r_rnd - 4'd1;
                  if (r_rnd == 4'd0) begin
                     r_dout     <= w_round;
                     r_dout_vld <= 1'b1;
                     r_last     <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // NOTE: the tables are not reset; the ready flags gate every use, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (w_idle && sbox_in_vld) begin
         for (int i = 0; i < 256; i++) begin
            r_fwd[i] <= sbox_in[8*i +: 8];
         end
      end
      if (r_state == INV_BUILD) begin
         r_inv[r_fwd[r_cnt]] <= r_cnt;
      end
`ifdef ROUND_KEY_CACHE_EN
      if (w_idle && !sbox_in_vld && key_in_vld && r_sbox_ok) begin
         r_rk[0] <= key_in;
      end
      if (r_state == KEY_EXP) begin
         r_rk[r_rnd] <= w_key_next;
      end
`endif
   end

endmodule
